// File: rtl/md4_hash_checker.sv
// md4_hash_checker
//   Compares a candidate 128-bit MD4 digest against a small table of target
//   digests. The table is scanned one entry per clock, lowest index first.
//   The first valid entry that matches stops the scan early. A miss always
//   takes DEPTH cycles.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   tgt_wr_en/idx/hash  : table write; sets the entry's valid bit (ignored while busy)
//   tgt_clear           : invalidate all entries (ignored while busy); a write
//                         in the same cycle survives the clear
//   checker_next_hash   : candidate digest, latched when a check starts
//   checker_checkrdy    : start a check (accepted in IDLE/DONE, ignored in SCAN)
//   checker_resultrdy   : result valid level, held in DONE
//   checker_matchfound  : candidate matched a valid entry
//   match_idx           : index of the first matching entry
//   busy                : high exactly while scanning
//   match_count         : saturating count of matches since reset
//
// Handshake: a check is accepted on any rising edge where checker_checkrdy=1
// and busy=0. The result is valid from the edge where checker_resultrdy rises
// until the next accepted check. There is no back-pressure on the result.
module md4_hash_checker #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_wr_en,
  input  logic [IDX_W-1:0] tgt_wr_idx,
  input  logic [127:0]     tgt_wr_hash,
  input  logic             tgt_clear,
  input  logic [127:0]     checker_next_hash,
  input  logic             checker_checkrdy,
  output logic             checker_resultrdy,
  output logic             checker_matchfound,
  output logic [IDX_W-1:0] match_idx,
  output logic             busy,
  output logic [15:0]      match_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

  // state_q is the observable FSM state for checkers.
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [127:0]     hash_q, hash_d;
  logic             resultrdy_q, resultrdy_d;
  logic             matchfound_q, matchfound_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;
  logic [15:0]      match_count_q, match_count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [127:0]     table_q [DEPTH];

  logic scanning;
  logic tbl_wr;
  logic hit;
  logic last;

  assign scanning = (state_q == SCAN);
  assign tbl_wr   = tgt_wr_en && !scanning;
  assign hit      = valid_q[idx_q] && (table_q[idx_q] == hash_q);
  assign last     = (idx_q == IDX_W'(DEPTH - 1));

  // Valid bits: clear first, then a same-cycle write marks its entry valid.
  always_comb begin
    valid_d = valid_q;
    if (!scanning) begin
      if (tgt_clear) valid_d = '0;
      if (tgt_wr_en) valid_d[tgt_wr_idx] = 1'b1;
    end
  end

  // Entry data needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (tbl_wr) table_q[tgt_wr_idx] <= tgt_wr_hash;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    hash_d        = hash_q;
    resultrdy_d   = resultrdy_q;
    matchfound_d  = matchfound_q;
    match_idx_d   = match_idx_q;
    match_count_d = match_count_q;
    case (state_q)
      IDLE, DONE: begin
        if (checker_checkrdy) begin
          hash_d       = checker_next_hash;
          idx_d        = '0;
          resultrdy_d  = 1'b0;
          matchfound_d = 1'b0;
          match_idx_d  = '0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          resultrdy_d  = 1'b1;
          matchfound_d = 1'b1;
          match_idx_d  = idx_q;
          if (match_count_q != 16'hFFFF) match_count_d = match_count_q + 16'd1;
          state_d      = DONE;
        end else if (last) begin
          resultrdy_d  = 1'b1;
          matchfound_d = 1'b0;
          state_d      = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      hash_q        <= '0;
      resultrdy_q   <= 1'b0;
      matchfound_q  <= 1'b0;
      match_idx_q   <= '0;
      match_count_q <= '0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hash_q        <= hash_d;
      resultrdy_q   <= resultrdy_d;
      matchfound_q  <= matchfound_d;
      match_idx_q   <= match_idx_d;
      match_count_q <= match_count_d;
      valid_q       <= valid_d;
    end
  end

  assign checker_resultrdy  = resultrdy_q;
  assign checker_matchfound = matchfound_q;
  assign match_idx          = match_idx_q;
  assign busy               = scanning;
  assign match_count        = match_count_q;

endmodule

// File: tb/tb_md4_hash_checker.sv
// Testbench for md4_hash_checker: directed scenarios plus randomized table
// contents and candidates, checked against a behavioural table model.
module tb_md4_hash_checker;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk;
  logic             rst_n;
  logic             tgt_wr_en;
  logic [IDX_W-1:0] tgt_wr_idx;
  logic [127:0]     tgt_wr_hash;
  logic             tgt_clear;
  logic [127:0]     checker_next_hash;
  logic             checker_checkrdy;
  logic             checker_resultrdy;
  logic             checker_matchfound;
  logic [IDX_W-1:0] match_idx;
  logic             busy;
  logic [15:0]      match_count;

  md4_hash_checker #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .tgt_wr_en(tgt_wr_en), .tgt_wr_idx(tgt_wr_idx), .tgt_wr_hash(tgt_wr_hash),
    .tgt_clear(tgt_clear),
    .checker_next_hash(checker_next_hash), .checker_checkrdy(checker_checkrdy),
    .checker_resultrdy(checker_resultrdy), .checker_matchfound(checker_matchfound),
    .match_idx(match_idx), .busy(busy), .match_count(match_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: the table as plain arrays
  logic [127:0] m_tab [DEPTH];
  bit           m_val [DEPTH];
  int           m_count;
  logic [127:0] pool [4];

  // scoreboard
  logic [IDX_W:0] exp_q[$];  // {matchfound, idx}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int first_hit(input logic [127:0] h);
    for (int i = 0; i < DEPTH; i++)
      if (m_val[i] && m_tab[i] == h) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    m_count = 0;
  endfunction

  // driver tasks (inputs change 1 time unit after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int idx, input logic [127:0] h, input bit clr);
    tgt_wr_en = 1'b1; tgt_wr_idx = IDX_W'(idx); tgt_wr_hash = h; tgt_clear = clr;
    tick();
    tgt_wr_en = 1'b0; tgt_clear = 1'b0;
    if (clr) for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
    m_tab[idx] = h; m_val[idx] = 1;
  endtask

  task automatic clear_table();
    tgt_clear = 1'b1;
    tick();
    tgt_clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_val[i] = 0;
  endtask

  // Run one check. do_wr writes an entry in the same accepting cycle;
  // disturb injects a foreign checkrdy and a table write mid-scan.
  task automatic run_check(input string tag, input logic [127:0] h, input bit do_wr,
                           input int wi, input logic [127:0] wh, input bit disturb);
    int hit, lat, cycles;
    logic [IDX_W:0] e;
    checker_next_hash = h; checker_checkrdy = 1'b1;
    if (do_wr) begin
      tgt_wr_en = 1'b1; tgt_wr_idx = IDX_W'(wi); tgt_wr_hash = wh;
    end
    tick();
    checker_checkrdy = 1'b0; tgt_wr_en = 1'b0;
    if (do_wr) begin m_tab[wi] = wh; m_val[wi] = 1; end
    hit = first_hit(h);
    lat = (hit >= 0) ? hit + 1 : DEPTH;
    if (hit >= 0) begin
      exp_q.push_back({1'b1, IDX_W'(hit)});
      if (m_count < 16'hFFFF) m_count++;
    end else begin
      exp_q.push_back({1'b0, IDX_W'(0)});
    end
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_rdy_clr"}, checker_resultrdy, 0);
    cycles = 0;
    while (!checker_resultrdy && cycles < 4 * DEPTH) begin
      if (disturb && cycles == 2) begin
        checker_checkrdy = 1'b1; checker_next_hash = ~h;
      end
      if (disturb && cycles == 3) begin
        tgt_wr_en = 1'b1; tgt_wr_idx = IDX_W'(wi); tgt_wr_hash = ~wh;
      end
      tick();
      checker_checkrdy = 1'b0; tgt_wr_en = 1'b0;
      cycles++;
    end
    check({tag, "_latency"}, cycles, lat);
    e = exp_q.pop_front();
    check({tag, "_match"}, checker_matchfound, e[IDX_W]);
    if (e[IDX_W]) check({tag, "_idx"}, match_idx, e[IDX_W-1:0]);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_count"}, match_count, m_count);
  endtask

  localparam logic [127:0] H1 = 128'h31D6CFE0D16AE931B73C59D7E0C089C0;
  localparam logic [127:0] H2 = 128'h0123456789ABCDEFFEDCBA9876543210;

  initial begin
    rst_n = 1'b0; tgt_wr_en = 1'b0; tgt_wr_idx = '0; tgt_wr_hash = '0; tgt_clear = 1'b0;
    checker_next_hash = '0; checker_checkrdy = 1'b0;
    model_reset();
    #12;
    check("rst_resultrdy", checker_resultrdy, 0);
    check("rst_matchfound", checker_matchfound, 0);
    check("rst_busy", busy, 0);
    check("rst_count", match_count, 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // entry 5 hit, then miss with candidate 0
    write_entry(5, H1, 0);
    run_check("hit5", H1, 0, 0, '0, 0);
    tick(); tick();
    check("hold_rdy", checker_resultrdy, 1);
    check("hold_idx", match_idx, 5);
    run_check("miss0", 128'h0, 0, 0, '0, 0);

    // duplicates: lowest index wins; clear in DONE forces a miss
    write_entry(2, H2, 0);
    write_entry(6, H2, 0);
    run_check("dup", H2, 0, 0, '0, 0);
    clear_table();
    run_check("cleared", H2, 0, 0, '0, 0);

    // clear + write together leaves only the written entry valid
    write_entry(5, H1, 1);
    run_check("clrwr", H1, 0, 0, '0, 0);

    // write and check in the same accepting cycle
    run_check("samecyc", H2, 1, 1, H2, 0);

    // mid-scan checkrdy and write are ignored; table unmodified afterwards
    run_check("disturb", H1, 0, 5, H1, 1);
    run_check("after_dist", H1, 0, 0, '0, 0);

    // reset during scan at scan cycle 4
    checker_next_hash = H1; checker_checkrdy = 1'b1;
    tick();
    checker_checkrdy = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdy", checker_resultrdy, 0);
    check("mid_rst_count", match_count, 0);
    model_reset();
    repeat (DEPTH + 2) @(posedge clk);
    check("mid_rst_norslt", checker_resultrdy, 0);
    @(negedge clk); rst_n = 1'b1;
    #4;
    run_check("post_rst_miss", H1, 0, 0, '0, 0);
    write_entry(7, H1, 0);
    run_check("post_rst_hit", H1, 0, 0, '0, 0);

    // randomized
    for (int i = 0; i < 4; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int it = 0; it < 25; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op == 0) clear_table();
      else if (op < 6) write_entry($urandom_range(0, DEPTH - 1), pool[$urandom_range(0, 3)], 0);
      if ($urandom_range(0, 4) == 0)
        run_check("rnd_new", {$urandom, $urandom, $urandom, $urandom}, 0, 0, '0, 0);
      else
        run_check("rnd", pool[$urandom_range(0, 3)], $urandom_range(0, 1) == 1,
                  $urandom_range(0, DEPTH - 1), pool[$urandom_range(0, 3)], 0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/md4_hash_checker.md
MD4_HASH_CHECKER -- requirements
Module: md4_hash_checker

Interface
REQ-001 Parameter DEPTH, default 8, number of target-hash table entries (power of two, 2..64).
REQ-002 Parameter IDX_W, default 3, width of the table index; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 tgt_wr_en  input  1  write target entry this cycle.
REQ-006 tgt_wr_idx  input  IDX_W  target entry index for write.
REQ-007 tgt_wr_hash  input  128  target hash value, in byte-swapped digest order, identical to the candidate format.
REQ-008 tgt_clear  input  1  invalidate all target entries.
REQ-009 checker_next_hash  input  128  candidate hash from the password generator.
REQ-010 checker_checkrdy  input  1  start-check pulse from the password generator.
REQ-011 checker_resultrdy  output  1  result valid (level).
REQ-012 checker_matchfound  output  1  candidate equals a valid target; qualified by checker_resultrdy.
REQ-013 match_idx  output  IDX_W  index of the matching entry; qualified by checker_matchfound.
REQ-014 busy  output  1  high while in SCAN.
REQ-015 match_count  output  16  total matches since reset; saturates at 16'hFFFF.

Function
REQ-016 The block SHALL hold a table of DEPTH 128-bit entries, each with a valid bit.
REQ-017 FSM states: IDLE, SCAN, DONE; reset state IDLE.
REQ-018 In IDLE or DONE, with checker_checkrdy=1 at edge N, the block SHALL:
- latch checker_next_hash;
- set scan index to 0;
- clear checker_resultrdy, checker_matchfound and match_idx;
- enter SCAN.
REQ-019 In SCAN, at each edge the block SHALL compare the latched hash against entry[idx]; an entry is a hit only if it is valid and all 128 bits are equal.
REQ-020 On a hit at entry j, at edge N+1+j the block SHALL:
- set checker_matchfound=1, match_idx=j, checker_resultrdy=1;
- increment match_count (saturating);
- enter DONE.
The first (lowest-index) hit wins.
REQ-021 If there is no hit through entry DEPTH-1, at edge N+DEPTH the block SHALL set checker_resultrdy=1 and checker_matchfound=0, and enter DONE.
REQ-022 The scan SHALL visit all DEPTH entries even when no entry is valid; miss latency is always DEPTH cycles.
REQ-023 In DONE, checker_resultrdy, checker_matchfound and match_idx SHALL hold until the next accepted checker_checkrdy or reset.
REQ-024 checker_checkrdy asserted during SCAN SHALL be ignored; the check in progress is unaffected.
REQ-025 checker_checkrdy held high for several cycles SHALL start exactly one check per cycle it is seen in IDLE/DONE; a level held into DONE restarts a check.
REQ-026 tgt_wr_en SHALL write entry[tgt_wr_idx] and set its valid bit at the edge, but only when busy=0; it SHALL be ignored in SCAN.
REQ-027 tgt_clear SHALL clear all valid bits when busy=0 and SHALL be ignored in SCAN; if asserted together with tgt_wr_en, the clear applies first and the written entry ends up valid.
REQ-028 A table write and checker_checkrdy in the same IDLE cycle SHALL both take effect, and the scan SHALL see the newly written entry.
REQ-029 busy SHALL be 1 exactly while the state is SCAN.

Reset
REQ-030 rst_n=0 SHALL immediately set the state to IDLE and the scan index to 0.
REQ-031 rst_n=0 SHALL immediately set checker_resultrdy, checker_matchfound, match_idx, busy and match_count to 0 and clear all valid bits; entry data is don't-care.
REQ-032 Reset during SCAN SHALL abort the check with no result pulse, and no match count is recorded.
REQ-033 After rst_n deasserts, the block SHALL accept checker_checkrdy on the first rising edge.

Verification
REQ-034 Write entry 5 = 128'h31D6CFE0D16AE931B73C59D7E0C089C0; pulse checkrdy with the same hash -> resultrdy=1 and matchfound=1 with match_idx=5, 6 cycles after the pulse edge; match_count=1.
REQ-035 Same table, candidate 128'h0 -> resultrdy=1 and matchfound=0 at 8 cycles after the pulse edge; match_count unchanged.
REQ-036 Entries 2 and 6 both hold hash H, candidate H -> match_idx=2 at 3 cycles; then tgt_clear in DONE and recheck H -> miss at 8 cycles.
REQ-037 checkrdy pulse at SCAN cycle 3 with a different hash, plus tgt_wr_en at SCAN cycle 4 -> the original result is returned unchanged and the table is unmodified.
REQ-038 rst_n pulsed low at SCAN cycle 4 -> all outputs 0 at once, no resultrdy follows, and a fresh check after release completes normally.
